// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the digit-serial twiddle multiplier.
package twiddle_pkg;

  localparam int DW     = 16;
  localparam int ND     = 11;
  localparam int CODE_W = 24;
  localparam int ACC_W  = DW + ND + 3;
  localparam int CNT_W  = 4;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;
  localparam logic [1:0] DIG_ILL  = 2'b11;

  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO  = ~SAT_HI;
  localparam logic signed [DW-1:0]    OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]    OUT_MAX = ~OUT_MIN;

  typedef enum logic [1:0] {Q_ID, Q_MJ, Q_NEG, Q_PJ} quad_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  function automatic logic signed [DW-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return OUT_MAX;
    else if (v < SAT_LO) return OUT_MIN;
    else                 return v[DW-1:0];
  endfunction

  // Two's-complement negation of the most negative value would wrap; clamp it.
  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
    return (v == OUT_MIN) ? OUT_MAX : -v;
  endfunction

endpackage

// File: rtl/sd_accum.sv
// One channel of the signed-digit shift-and-add multiply; result is floored and saturated.
module sd_accum
  import twiddle_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [1:0]       digit,
  input  logic [CNT_W-1:0] shift,
  input  logic [DW-1:0]    x,
  output logic [DW-1:0]    y
);

  logic signed [DW-1:0]    x_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] xe;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_int;

  // Pre-shifting by ND-1 keeps every partial product xe >>> j exact.
  assign xe      = {{(ACC_W-DW){x_q[DW-1]}}, x_q} <<< (ND - 1);
  assign term    = xe >>> shift;
  assign acc_int = acc >>> (ND - 1);
  assign y       = saturate(acc_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      acc <= '0;
    end else if (clear) begin
      x_q <= $signed(x);
      acc <= '0;
    end else if (step) begin
      case (digit)
        DIG_POS: acc <= acc + term;
        DIG_NEG: acc <= acc - term;
        default: acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/twiddle_sd_mult.sv
// Digit-serial complex twiddle multiplier: signed-digit scale then quadrant rotation.
//   state | meaning
//   IDLE  | ready for a sample + code
//   CALC  | one signed digit per cycle, 11 cycles
//   DONE  | result held until downstream accepts
module twiddle_sd_mult
  import twiddle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_re,
  input  logic [DW-1:0]     in_im,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im,
  output logic              out_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ND - 1);

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CODE_W-1:0]   code_q;
  logic                err;
  logic                accept;
  logic                step;
  logic [1:0]          digit;
  logic [DW-1:0]       acc_re, acc_im;
  logic signed [DW-1:0] cr, ci;
  quad_e               quad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      code_q <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      code_q <= in_code;
      err    <= 1'b0;
    end else if (step) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (digit == DIG_ILL) err <= 1'b1;
    end
  end

  // Digit j lives at code[21-2j -: 2], most significant first.
  always_comb begin
    digit = DIG_ZERO;
    for (int j = 0; j < ND; j++) begin
      if (cnt == CNT_W'(j)) digit = code_q[21-2*j -: 2];
    end
  end

  sd_accum u_acc_re (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (step),
    .digit (digit),
    .shift (cnt),
    .x     (in_re),
    .y     (acc_re)
  );

  sd_accum u_acc_im (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (step),
    .digit (digit),
    .shift (cnt),
    .x     (in_im),
    .y     (acc_im)
  );

  assign cr   = $signed(acc_re);
  assign ci   = $signed(acc_im);
  assign quad = quad_e'(code_q[CODE_W-1 -: 2]);

  always_comb begin
    out_re = cr;
    out_im = ci;
    case (quad)
      Q_MJ: begin
        out_re = ci;
        out_im = neg_sat(cr);
      end
      Q_NEG: begin
        out_re = neg_sat(cr);
        out_im = neg_sat(ci);
      end
      Q_PJ: begin
        out_re = neg_sat(ci);
        out_im = cr;
      end
      default: begin
        out_re = cr;
        out_im = ci;
      end
    endcase
  end

  assign out_err = err;

endmodule

// File: tb/tb_twiddle_sd_mult.sv
// Self-checking bench for twiddle_sd_mult against a plain-arithmetic reference model.
module tb_twiddle_sd_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re, in_im;
  logic [23:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re, out_im;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  twiddle_sd_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int sneg(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  // Coefficient as an integer in units of 2^-10, product floored, saturated, rotated.
  function automatic void model(input int xr, input int xi, input logic [23:0] code,
                                output int yr, output int yi, output bit e);
    int v;
    int cr, ci;
    logic [1:0] d;
    v = 0;
    e = 1'b0;
    for (int j = 0; j < 11; j++) begin
      d = code[21-2*j -: 2];
      if (d == 2'b01)      v += (1 << (10 - j));
      else if (d == 2'b10) v -= (1 << (10 - j));
      else if (d == 2'b11) e = 1'b1;
    end
    cr = clamp16((longint'(xr) * v) >>> 10);
    ci = clamp16((longint'(xi) * v) >>> 10);
    case (code[23:22])
      2'b00: begin yr = cr;       yi = ci;       end
      2'b01: begin yr = ci;       yi = sneg(cr); end
      2'b10: begin yr = sneg(cr); yi = sneg(ci); end
      default: begin yr = sneg(ci); yi = cr;    end
    endcase
  endfunction

  task automatic run_txn(input int xr, input int xi, input logic [23:0] code, input bit early,
                         output int gr, output int gi, output bit ge, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_re     = xr[15:0];
    in_im     = xi[15:0];
    in_code   = code;
    in_valid  = 1'b1;
    out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_re    = 16'($urandom);
    in_im    = 16'($urandom);
    in_code  = 24'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    gr = int'($signed(out_re));
    gi = int'($signed(out_im));
    ge = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; in_code = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_re !== 16'h0) begin n_fail++; $display("FAIL reset_out_re: got %h expected 0", out_re); end
    n_checks++; if (out_im !== 16'h0) begin n_fail++; $display("FAIL reset_out_im: got %h expected 0", out_im); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [23:0] codes [7] = '{24'h100000, 24'h180000, 24'h140000, 24'h500000, 24'hD00000, 24'h300000, 24'h100000};
    int xr [7] = '{1000, 1000, 30000, 100, 100, 1234, 1234};
    int xi [7] = '{-500, -3, -30000, 200, 200, -77, -77};
    int er [7] = '{1000, 500, 32767, 200, -200, 0, 1234};
    int ei [7] = '{-500, -2, -32768, -100, 100, 0, -77};
    bit ee [7] = '{0, 0, 0, 0, 0, 1, 0};
    int gr, gi, lat;
    bit ge;
    for (int k = 0; k < 7; k++) begin
      run_txn(xr[k], xi[k], codes[k], (k == 0), gr, gi, ge, lat);
      n_checks++; if (gr !== er[k]) begin n_fail++; $display("FAIL directed_re[%0d]: got %0d expected %0d", k, gr, er[k]); end
      n_checks++; if (gi !== ei[k]) begin n_fail++; $display("FAIL directed_im[%0d]: got %0d expected %0d", k, gi, ei[k]); end
      n_checks++; if (ge !== ee[k]) begin n_fail++; $display("FAIL directed_err[%0d]: got %0d expected %0d", k, ge, ee[k]); end
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 11", k, lat); end
    end
  endtask

  task automatic test_random();
    logic [23:0] code;
    int xr, xi, yr, yi, gr, gi, lat;
    bit ye, ge;
    for (int k = 0; k < 40; k++) begin
      code[23:22] = 2'($urandom_range(0, 3));
      for (int j = 0; j < 11; j++)
        code[21-2*j -: 2] = ($urandom_range(0, 24) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: begin xr = -32768; xi = 32767; end
        default: begin xr = int'($signed(16'($urandom))); xi = int'($signed(16'($urandom))); end
      endcase
      model(xr, xi, code, yr, yi, ye);
      run_txn(xr, xi, code, bit'($urandom_range(0, 1)), gr, gi, ge, lat);
      n_checks++; if (gr !== yr) begin n_fail++; $display("FAIL random_re[%0d]: code %h x %0d got %0d expected %0d", k, code, xr, gr, yr); end
      n_checks++; if (gi !== yi) begin n_fail++; $display("FAIL random_im[%0d]: code %h x %0d got %0d expected %0d", k, code, xi, gi, yi); end
      n_checks++; if (ge !== ye) begin n_fail++; $display("FAIL random_err[%0d]: code %h got %0d expected %0d", k, code, ge, ye); end
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected 11", k, lat); end
    end
  endtask

  task automatic test_backpressure();
    int yr, yi, lat;
    bit ye;
    model(-20000, 12345, 24'hA40000, yr, yi, ye);
    in_re = 16'(-20000); in_im = 16'(12345); in_code = 24'hA40000;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, out_valid); end
      n_checks++; if (int'($signed(out_re)) !== yr) begin n_fail++; $display("FAIL hold_re[%0d]: got %0d expected %0d", c, $signed(out_re), yr); end
      n_checks++; if (int'($signed(out_im)) !== yi) begin n_fail++; $display("FAIL hold_im[%0d]: got %0d expected %0d", c, $signed(out_im), yi); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Illegal first digit plus a nonzero sample so err and partial outputs are live when reset hits.
    in_re = 16'd5000; in_im = 16'd7000; in_code = 24'h370000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_re !== 16'h0) begin n_fail++; $display("FAIL rst_mid_re: got %h expected 0", out_re); end
    n_checks++; if (out_im !== 16'h0) begin n_fail++; $display("FAIL rst_mid_im: got %h expected 0", out_im); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", out_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    in_re = 16'd1000; in_im = 16'(-500); in_code = 24'h100000;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (in_ready) acc_cyc.push_back(c);
      if (out_valid) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept[%0d]: in_ready %b expected 0", c, in_ready); end
        n_checks++; if (int'($signed(out_re)) !== 1000) begin n_fail++; $display("FAIL b2b_re[%0d]: got %0d expected 1000", c, $signed(out_re)); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (acc_cyc.size() < 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected at least 3", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 13) begin
        n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected 13", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    repeat (15) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
